// File: rtl/uart_frame_mux.sv
// ============================================================================
// Module   : uart_frame_mux
// Brief    : Packs a status byte and CHANNELS fields into checksummed UART
//            byte frames with a one-deep request queue and valid/ready output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_mux #(
    parameter int         CHANNELS  = 6,
    parameter int         FIELD_W   = 12,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         FRAME_GAP = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CHANNELS*FIELD_W-1:0] fields_in,
    input  logic [7:0]                  flags_in,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam logic [3:0] C_LAST_CH  = 4'(CHANNELS - 1);
    localparam logic [7:0] C_GAP_LAST = (FRAME_GAP > 0) ? 8'(FRAME_GAP - 1) : 8'd0;
    localparam bit         C_NO_GAP   = (FRAME_GAP == 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_SEQ   = 3'd2,
        S_FLAGS = 3'd3,
        S_FHI   = 3'd4,
        S_FLO   = 3'd5,
        S_CSUM  = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    state_t        r_state;
    logic [7:0]    r_seq;
    logic [7:0]    r_sum;
    logic [7:0]    r_gap_cnt;
    logic [3:0]    r_ch_idx;
    logic          r_pending;
    logic [255:0]  r_fields;
    logic [7:0]    r_flags;
    logic [255:0]  r_shadow_fields;
    logic [7:0]    r_shadow_flags;

    logic [255:0]  w_fields_ext;
    logic [15:0]   w_cur_field;
    logic [15:0]   w_nxt_field;
    logic [3:0]    w_nxt_ch;
    logic          w_xfer;
    logic          w_finish;

    // Every field is widened to a 16-bit slot so the byte selector is a plain shift.
    for (genvar k = 0; k < 16; k++) begin : g_ext
        if (k < CHANNELS) begin : g_used
            assign w_fields_ext[k*16 +: 16] = 16'(fields_in[k*FIELD_W +: FIELD_W]);
        end else begin : g_pad
            assign w_fields_ext[k*16 +: 16] = 16'd0;
        end
    end

    assign w_nxt_ch    = r_ch_idx + 4'd1;
    assign w_cur_field = r_fields[{r_ch_idx, 4'd0} +: 16];
    assign w_nxt_field = r_fields[{w_nxt_ch, 4'd0} +: 16];
    assign w_xfer      = tx_valid & tx_ready;
    assign w_finish    = ((r_state == S_CSUM) && w_xfer && C_NO_GAP) ||
                         ((r_state == S_GAP) && (r_gap_cnt == 8'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_seq           <= 8'd0;
            r_sum           <= 8'd0;
            r_gap_cnt       <= 8'd0;
            r_ch_idx        <= 4'd0;
            r_pending       <= 1'b0;
            r_fields        <= '0;
            r_flags         <= 8'd0;
            r_shadow_fields <= '0;
            r_shadow_flags  <= 8'd0;
            tx_data         <= 8'd0;
            tx_valid        <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            // A request on the frame-completion edge is consumed below instead.
            if (r_state != S_IDLE && !w_finish && start) begin
                if (r_pending) begin
                    overrun <= 1'b1;
                end else begin
                    r_pending       <= 1'b1;
                    r_shadow_fields <= w_fields_ext;
                    r_shadow_flags  <= flags_in;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SYNC;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        busy     <= 1'b1;
                        r_fields <= w_fields_ext;
                        r_flags  <= flags_in;
                    end
                end
                S_SYNC: begin
                    if (w_xfer) begin
                        r_state <= S_SEQ;
                        tx_data <= r_seq;
                        r_sum   <= r_seq;
                    end
                end
                S_SEQ: begin
                    if (w_xfer) begin
                        r_state <= S_FLAGS;
                        tx_data <= r_flags;
                        r_sum   <= r_sum + r_flags;
                    end
                end
                S_FLAGS: begin
                    if (w_xfer) begin
                        r_state <= S_FHI;
                        tx_data <= w_cur_field[15:8];
                        r_sum   <= r_sum + w_cur_field[15:8];
                    end
                end
                S_FHI: begin
                    if (w_xfer) begin
                        r_state <= S_FLO;
                        tx_data <= w_cur_field[7:0];
                        r_sum   <= r_sum + w_cur_field[7:0];
                    end
                end
                S_FLO: begin
                    if (w_xfer) begin
                        if (r_ch_idx == C_LAST_CH) begin
                            r_state  <= S_CSUM;
                            tx_data  <= 8'd0 - r_sum;
                            r_ch_idx <= 4'd0;
                        end else begin
                            r_state  <= S_FHI;
                            r_ch_idx <= w_nxt_ch;
                            tx_data  <= w_nxt_field[15:8];
                            r_sum    <= r_sum + w_nxt_field[15:8];
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        frame_done <= 1'b1;
                        r_seq      <= r_seq + 8'd1;
                        if (!C_NO_GAP) begin
                            r_state   <= S_GAP;
                            tx_valid  <= 1'b0;
                            tx_data   <= 8'd0;
                            r_gap_cnt <= C_GAP_LAST;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != 8'd0) begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // End of frame: chain straight into the queued or coincident request.
            if (w_finish) begin
                if (r_pending || start) begin
                    r_state  <= S_SYNC;
                    tx_valid <= 1'b1;
                    tx_data  <= SYNC_BYTE;
                    busy     <= 1'b1;
                    if (r_pending) begin
                        r_fields  <= r_shadow_fields;
                        r_flags   <= r_shadow_flags;
                        r_pending <= start;
                        if (start) begin
                            r_shadow_fields <= w_fields_ext;
                            r_shadow_flags  <= flags_in;
                        end
                    end else begin
                        r_fields <= w_fields_ext;
                        r_flags  <= flags_in;
                    end
                end else begin
                    r_state  <= S_IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'd0;
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire
